pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the multi-issue CPU pipeline, replacing hand-written per-stage registers such as the EX/MEM boundary. It carries `LANES` issue lanes of `DATA_W`-bit payload with per-lane valid bits. It supports two modes:

- **Mode 0:** the legacy global stall/flush/bubble protocol.
- **Mode 1:** a ready/valid elastic mode with a 2-entry skid buffer.

It also adds per-lane kill on capture, optional data clearing, and saturating stall/bubble performance counters.

## Interface
Parameters:
- `LANES`, 2, number of issue lanes.
- `DATA_W`, 64, payload bits per lane; packed as `{PipeReq, PipeData}` by the instantiating stage.
- `MODE`, 0: 0 = stall/flush protocol, 1 = ready/valid with skid buffer.
- `CLEAR_DATA`, 1: 1 = zero the payload on reset, flush or bubble; 0 = clear valid bits only.
- `CNT_W`, 32, perf counter width.

Ports:
- `clk`, in, 1, clock. Single clock domain.
- `rst`, in, 1, reset; synchronous, active-high.
- `in_valid`, in, `LANES`, per-lane valid from the upstream stage.
- `in_data`, in, `LANES*DATA_W`, lane payloads; lane i occupies bits `[i*DATA_W +: DATA_W]`.
- `kill_mask`, in, `LANES`, lanes forced invalid on capture. Used by younger-lane squash after a branch or exception in an older lane.
- `flush`, in, 1, pipeline flush.
- `stall_up`, in, 1, upstream stage stalled (`stall_ex` equivalent). Mode 0 only.
- `stall_down`, in, 1, downstream stage stalled (`stall_mem` equivalent). Mode 0 only.
- `in_ready`, out, 1, stage can accept a bundle. Mode 1 only; tied to 1 in Mode 0.
- `out_ready`, in, 1, downstream accepts the bundle. Mode 1 only; ignored in Mode 0.
- `out_valid`, out, `LANES`, registered per-lane valid.
- `out_data`, out, `LANES*DATA_W`, registered payloads.
- `cnt_clr`, in, 1, synchronous clear of both counters.
- `stall_cnt`, out, `CNT_W`, saturating count of hold cycles.
- `bubble_cnt`, out, `CNT_W`, saturating count of empty-output cycles.

## Operation
**Reset values.** `out_valid`=0, `out_data`=0, `stall_cnt`=0, `bubble_cnt`=0, skid buffer empty. In Mode 1, `in_ready`=1 one cycle after reset deasserts.

**Mode 0.** One priority chain, evaluated each clock edge:
1. `rst` or `flush`: `out_valid`←0. If `CLEAR_DATA`, `out_data`←0.
2. `stall_up & ~stall_down`: insert a bubble. Same effect as step 1.
3. `~stall_up`: `out_data`←`in_data`, `out_valid`←`in_valid & ~kill_mask`.
4. Otherwise (`stall_up & stall_down`): hold all outputs.

**Mode 1 bundle rules.**
- A bundle is the whole lane vector. Lanes never transfer independently.
- Enqueue happens when `(|in_valid) & in_ready`. The stored valid is `in_valid & ~kill_mask`. A bundle that is all-killed is still enqueued as an empty slot. This keeps ordering simple.
- Dequeue happens when `(|out_valid) & out_ready`.

**Mode 1 skid buffer.**
- Storage is a main register (drives the outputs) plus one skid entry. Occupancy ranges 0..2.
- Enqueue with the main register empty, or dequeuing in the same cycle, writes to main. Otherwise the bundle is written to skid.
- After a dequeue, a valid skid entry moves to main in the same edge.
- Simultaneous enqueue and dequeue at occupancy 2 is impossible, because `in_ready`=0 at occupancy 2.
- `in_ready` = ~skid_occupied, registered, with no combinational path from `out_ready`.

**Mode 1 flush.** `flush` empties both entries. Any enqueue attempted in the same cycle is dropped.

**Counters.**
- Increment only when `rst` and `cnt_clr` are both low. Both saturate at all-ones.
- `cnt_clr` takes priority over increment.
- `stall_cnt` increments on:
  - Mode 0: cycles with `stall_up & stall_down & ~flush`.
  - Mode 1: cycles with `(|out_valid) & ~out_ready`.
- `bubble_cnt` increments on:
  - Mode 0: cycles applying step 2.
  - Mode 1: cycles with `out_ready & ~(|out_valid)`.

## Timing
- **Latency:** 1 cycle input to output in both modes when not stalled.
- **Mode 1 throughput:** 1 bundle/cycle sustained while `out_ready`=1. After `out_ready` drops, 1 extra bundle is absorbed by the skid entry, then `in_ready` falls in the following cycle.
- **Outputs:** all outputs are registered. No combinational input→output path, except nothing. `in_ready` is a flop output.
- **Simultaneous events:**
  - `flush` overrides stall, bubble and enqueue.
  - `rst` overrides everything.
  - `kill_mask` is sampled only on capture.

## Structure
- **Shared package (`cpu_defs`):** add the `PipeMode_t` enum (`PIPE_STALL`, `PIPE_ELASTIC`). Stage payload structs continue to be packed into `DATA_W` by the instantiating stage.
- **Sub-module:** `pipe_skid_buf`, holding the 2-entry storage, occupancy state and `in_ready` for Mode 1. It is generated only when `MODE`=1. Counters stay in the top module.

## Test plan
1. **Mode 0 capture and kill.** `LANES`=2, `in_valid`=2'b11, `kill_mask`=2'b10, no stall → next cycle `out_valid`=2'b01, lane 0 data equal to input.
2. **Mode 0 bubble, hold, flush.**
   - `stall_up`=1, `stall_down`=0 → `out_valid`=0, `out_data`=0, `bubble_cnt`=1.
   - Then both stall signals high for 3 cycles → outputs unchanged, `stall_cnt`=3.
   - `flush` together with both stall signals → outputs cleared.
3. **Mode 1 streaming.** Stream bundles 1..8 with `out_ready`=1 → outputs 1..8 on consecutive cycles, `in_ready` constantly 1.
4. **Mode 1 backpressure.**
   - Drop `out_ready` while streaming → exactly one extra bundle is accepted, then `in_ready`=0.
   - Raise `out_ready` → order is preserved with no loss or duplication.
5. **Mode 1 flush.** `flush` at occupancy 2 with `in_valid` high → both entries are discarded, `out_valid`=0, `in_ready`=1 next cycle.
6. **Counter saturation and clear.** `CNT_W`=4, 20 hold cycles → `stall_cnt`=4'hF. Then `cnt_clr` → 0. Then `rst` mid-stream → all outputs at reset values.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU pipeline definitions: pipeline-register operating modes.
// Stage payload structs are packed into DATA_W by each instantiating stage.
package cpu_defs;

    typedef enum logic {
        PIPE_STALL   = 1'b0,
        PIPE_ELASTIC = 1'b1
    } PipeMode_t;

    function automatic PipeMode_t pipe_mode(input int mode);
        return (mode == 1) ? PIPE_ELASTIC : PIPE_STALL;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// 2-entry elastic storage (main register + skid entry) for ready/valid pipeline stages.
// Latency 1 cycle; in_ready is a flop cleared once the skid entry fills, so out_ready never reaches it combinationally.
module pipe_skid_buf
    import cpu_defs::*;
#(
    parameter int LANES      = 2,
    parameter int DATA_W     = 64,
    parameter int CLEAR_DATA = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    enq_req,
    input  logic [LANES-1:0]        enq_valid,
    input  logic [LANES*DATA_W-1:0] enq_data,
    input  logic                    deq_ready,
    output logic                    in_ready,
    output logic [LANES-1:0]        main_valid,
    output logic [LANES*DATA_W-1:0] main_data
);

    localparam int BW = LANES * DATA_W;

    logic             skid_occ;
    logic             skid_occ_nxt;
    logic [LANES-1:0] skid_valid;
    logic [LANES-1:0] skid_valid_nxt;
    logic [LANES-1:0] main_valid_nxt;
    logic [BW-1:0]    skid_data;
    logic [BW-1:0]    skid_data_nxt;
    logic [BW-1:0]    main_data_nxt;
    logic             main_full;
    logic             enq;
    logic             deq;

    assign main_full = |main_valid;
    assign deq       = main_full & deq_ready;
    assign enq       = enq_req & in_ready;

    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        skid_occ_nxt   = skid_occ;

        if (flush) begin
            main_valid_nxt = '0;
            skid_valid_nxt = '0;
            skid_occ_nxt   = 1'b0;
            if (CLEAR_DATA != 0) begin
                main_data_nxt = '0;
                skid_data_nxt = '0;
            end
        end else begin
            if (deq) begin
                if (skid_occ) begin
                    main_valid_nxt = skid_valid;
                    main_data_nxt  = skid_data;
                    skid_valid_nxt = '0;
                    skid_occ_nxt   = 1'b0;
                end else begin
                    main_valid_nxt = '0;
                end
            end
            // enq implies in_ready, hence skid empty: the deq branch above never moved skid here.
            if (enq) begin
                if (!main_full || deq) begin
                    main_valid_nxt = enq_valid;
                    main_data_nxt  = enq_data;
                end else begin
                    skid_valid_nxt = enq_valid;
                    skid_data_nxt  = enq_data;
                    skid_occ_nxt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= '0;
            skid_valid <= '0;
            skid_occ   <= 1'b0;
            in_ready   <= 1'b0;
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            main_valid <= main_valid_nxt;
            main_data  <= main_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            skid_occ   <= skid_occ_nxt;
            in_ready   <= ~skid_occ_nxt;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised multi-lane inter-stage pipeline register: global stall/flush/bubble or ready/valid skid mode.
// Latency 1 cycle; MODE 0 holds on stall_up & stall_down, MODE 1 absorbs one extra bundle then drops in_ready.
module pipe_stage_reg
    import cpu_defs::*;
#(
    parameter int LANES      = 2,
    parameter int DATA_W     = 64,
    parameter int MODE       = 0,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES-1:0]        kill_mask,
    input  logic                    flush,
    input  logic                    stall_up,
    input  logic                    stall_down,
    output logic                    in_ready,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam PipeMode_t       PMODE   = pipe_mode(MODE);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic out_any;
    logic stall_evt;
    logic bubble_evt;

    assign out_any = |out_valid;

    generate
        if (PMODE == PIPE_ELASTIC) begin : g_elastic
            pipe_skid_buf #(
                .LANES      (LANES),
                .DATA_W     (DATA_W),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_skid (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .enq_req    (|in_valid),
                .enq_valid  (in_valid & ~kill_mask),
                .enq_data   (in_data),
                .deq_ready  (out_ready),
                .in_ready   (in_ready),
                .main_valid (out_valid),
                .main_data  (out_data)
            );
        end else begin : g_stall
            assign in_ready = 1'b1;

            // Bubble (stall_up with downstream free) clears exactly like a flush.
            always_ff @(posedge clk) begin
                if (rst || flush || (stall_up && !stall_down)) begin
                    out_valid <= '0;
                    if (CLEAR_DATA != 0) begin
                        out_data <= '0;
                    end
                end else if (!stall_up) begin
                    out_data  <= in_data;
                    out_valid <= in_valid & ~kill_mask;
                end
            end
        end
    endgenerate

    assign stall_evt  = (PMODE == PIPE_ELASTIC) ? (out_any & ~out_ready)
                                                : (stall_up & stall_down & ~flush);
    assign bubble_evt = (PMODE == PIPE_ELASTIC) ? (out_ready & ~out_any)
                                                : (stall_up & ~stall_down & ~flush);

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (bubble_evt && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one stall-mode and one elastic-mode instance sharing stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  kill_mask;
    logic        flush, stall_up, stall_down, out_ready, cnt_clr;

    logic        m0_in_ready, m1_in_ready;
    logic [1:0]  m0_out_valid, m1_out_valid;
    logic [15:0] m0_out_data, m1_out_data;
    logic [3:0]  m0_stall_cnt, m0_bubble_cnt, m1_stall_cnt, m1_bubble_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.LANES(2), .DATA_W(8), .MODE(0), .CLEAR_DATA(1), .CNT_W(4)) u_m0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .kill_mask(kill_mask),
        .flush(flush), .stall_up(stall_up), .stall_down(stall_down), .in_ready(m0_in_ready),
        .out_ready(out_ready), .out_valid(m0_out_valid), .out_data(m0_out_data),
        .cnt_clr(cnt_clr), .stall_cnt(m0_stall_cnt), .bubble_cnt(m0_bubble_cnt)
    );

    pipe_stage_reg #(.LANES(2), .DATA_W(8), .MODE(1), .CLEAR_DATA(1), .CNT_W(4)) u_m1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .kill_mask(kill_mask),
        .flush(flush), .stall_up(stall_up), .stall_down(stall_down), .in_ready(m1_in_ready),
        .out_ready(out_ready), .out_valid(m1_out_valid), .out_data(m1_out_data),
        .cnt_clr(cnt_clr), .stall_cnt(m1_stall_cnt), .bubble_cnt(m1_bubble_cnt)
    );

    typedef struct {
        logic [1:0]  iv;
        logic [15:0] d;
        logic [1:0]  k;
        logic        fl, su, sd;
        logic [1:0]  ev;
        logic [15:0] ed;
        logic [3:0]  es, eb;
    } m0_vec_t;

    typedef struct {
        logic [1:0]  iv;
        logic [15:0] d;
        logic [1:0]  k;
        logic        fl, ordy;
        logic [1:0]  ev;
        logic        chk_d;
        logic [15:0] ed;
        logic        eir;
    } m1_vec_t;

    m0_vec_t m0_tab[11];
    m1_vec_t m1_tab[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " m0 out_valid"}, 32'(m0_out_valid), 32'h0);
        chk({tag, " m0 out_data"}, 32'(m0_out_data), 32'h0);
        chk({tag, " m0 stall_cnt"}, 32'(m0_stall_cnt), 32'h0);
        chk({tag, " m0 bubble_cnt"}, 32'(m0_bubble_cnt), 32'h0);
        chk({tag, " m1 out_valid"}, 32'(m1_out_valid), 32'h0);
        chk({tag, " m1 out_data"}, 32'(m1_out_data), 32'h0);
        chk({tag, " m1 stall_cnt"}, 32'(m1_stall_cnt), 32'h0);
        chk({tag, " m1 bubble_cnt"}, 32'(m1_bubble_cnt), 32'h0);
        chk({tag, " m1 in_ready"}, 32'(m1_in_ready), 32'h0);
    endtask

    initial begin
        //              iv     d        k      fl su sd  ev     ed       es    eb
        m0_tab[0]  = '{2'b11, 16'hB2A1, 2'b10, 0, 0, 0, 2'b01, 16'hB2A1, 4'd0, 4'd0};
        m0_tab[1]  = '{2'b11, 16'h4433, 2'b00, 0, 0, 0, 2'b11, 16'h4433, 4'd0, 4'd0};
        m0_tab[2]  = '{2'b11, 16'h5566, 2'b00, 0, 1, 0, 2'b00, 16'h0000, 4'd0, 4'd1};
        m0_tab[3]  = '{2'b11, 16'h7788, 2'b00, 0, 0, 0, 2'b11, 16'h7788, 4'd0, 4'd1};
        m0_tab[4]  = '{2'b11, 16'h9999, 2'b00, 0, 1, 1, 2'b11, 16'h7788, 4'd1, 4'd1};
        m0_tab[5]  = '{2'b11, 16'h9999, 2'b00, 0, 1, 1, 2'b11, 16'h7788, 4'd2, 4'd1};
        m0_tab[6]  = '{2'b11, 16'h9999, 2'b00, 0, 1, 1, 2'b11, 16'h7788, 4'd3, 4'd1};
        m0_tab[7]  = '{2'b11, 16'h9999, 2'b00, 1, 1, 1, 2'b00, 16'h0000, 4'd3, 4'd1};
        m0_tab[8]  = '{2'b01, 16'hABCD, 2'b00, 0, 0, 1, 2'b01, 16'hABCD, 4'd3, 4'd1};
        m0_tab[9]  = '{2'b11, 16'h1234, 2'b11, 0, 0, 0, 2'b00, 16'h1234, 4'd3, 4'd1};
        m0_tab[10] = '{2'b11, 16'h5678, 2'b00, 1, 0, 0, 2'b00, 16'h0000, 4'd3, 4'd1};

        //              iv     d        k      fl ordy ev    chk_d ed       eir
        m1_tab[0]  = '{2'b11, 16'h0101, 2'b00, 0, 1, 2'b11, 1, 16'h0101, 1};
        m1_tab[1]  = '{2'b11, 16'h0202, 2'b00, 0, 0, 2'b11, 1, 16'h0101, 0};
        m1_tab[2]  = '{2'b11, 16'h0303, 2'b00, 0, 0, 2'b11, 1, 16'h0101, 0};
        m1_tab[3]  = '{2'b11, 16'h0303, 2'b00, 0, 1, 2'b11, 1, 16'h0202, 1};
        m1_tab[4]  = '{2'b11, 16'h0303, 2'b00, 0, 1, 2'b11, 1, 16'h0303, 1};
        m1_tab[5]  = '{2'b00, 16'h0000, 2'b00, 0, 1, 2'b00, 0, 16'h0000, 1};
        m1_tab[6]  = '{2'b11, 16'h0404, 2'b00, 0, 0, 2'b11, 1, 16'h0404, 1};
        m1_tab[7]  = '{2'b11, 16'h0505, 2'b00, 0, 0, 2'b11, 1, 16'h0404, 0};
        m1_tab[8]  = '{2'b11, 16'h0606, 2'b00, 1, 0, 2'b00, 1, 16'h0000, 1};
        m1_tab[9]  = '{2'b00, 16'h0000, 2'b00, 0, 1, 2'b00, 1, 16'h0000, 1};
        m1_tab[10] = '{2'b11, 16'h0707, 2'b01, 0, 0, 2'b10, 1, 16'h0707, 1};
        m1_tab[11] = '{2'b11, 16'h0808, 2'b11, 0, 0, 2'b10, 1, 16'h0707, 0};
        m1_tab[12] = '{2'b00, 16'h0000, 2'b00, 0, 1, 2'b00, 0, 16'h0000, 1};
        m1_tab[13] = '{2'b11, 16'h0909, 2'b00, 0, 0, 2'b11, 1, 16'h0909, 1};
        m1_tab[14] = '{2'b00, 16'h0000, 2'b00, 0, 1, 2'b00, 0, 16'h0000, 1};

        rst = 1'b1; in_valid = '0; in_data = '0; kill_mask = '0;
        flush = 1'b0; stall_up = 1'b0; stall_down = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        step();
        step();
        chk_reset_state("reset");
        rst = 1'b0;
        step();
        chk("m1 in_ready after reset", 32'(m1_in_ready), 32'h1);
        chk("m0 in_ready tied", 32'(m0_in_ready), 32'h1);

        // Stall/flush protocol vectors.
        for (int i = 0; i < 11; i++) begin
            in_valid = m0_tab[i].iv; in_data = m0_tab[i].d; kill_mask = m0_tab[i].k;
            flush = m0_tab[i].fl; stall_up = m0_tab[i].su; stall_down = m0_tab[i].sd;
            step();
            chk($sformatf("m0[%0d] out_valid", i), 32'(m0_out_valid), 32'(m0_tab[i].ev));
            chk($sformatf("m0[%0d] out_data", i), 32'(m0_out_data), 32'(m0_tab[i].ed));
            chk($sformatf("m0[%0d] stall_cnt", i), 32'(m0_stall_cnt), 32'(m0_tab[i].es));
            chk($sformatf("m0[%0d] bubble_cnt", i), 32'(m0_bubble_cnt), 32'(m0_tab[i].eb));
        end

        // Elastic streaming: fresh state, 1 bundle/cycle.
        flush = 1'b0; stall_up = 1'b0; stall_down = 1'b0; kill_mask = '0; in_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            in_valid = 2'b11;
            in_data  = {8'(k + 16), 8'(k)};
            chk($sformatf("stream[%0d] in_ready", k), 32'(m1_in_ready), 32'h1);
            step();
            chk($sformatf("stream[%0d] out_valid", k), 32'(m1_out_valid), 32'h3);
            chk($sformatf("stream[%0d] out_data", k), 32'(m1_out_data), 32'({8'(k + 16), 8'(k)}));
        end
        in_valid = '0;
        step();
        chk("stream drain out_valid", 32'(m1_out_valid), 32'h0);

        // Elastic backpressure, flush at occupancy 2, killed bundles.
        for (int i = 0; i < 15; i++) begin
            in_valid = m1_tab[i].iv; in_data = m1_tab[i].d; kill_mask = m1_tab[i].k;
            flush = m1_tab[i].fl; out_ready = m1_tab[i].ordy;
            step();
            chk($sformatf("m1[%0d] out_valid", i), 32'(m1_out_valid), 32'(m1_tab[i].ev));
            if (m1_tab[i].chk_d)
                chk($sformatf("m1[%0d] out_data", i), 32'(m1_out_data), 32'(m1_tab[i].ed));
            chk($sformatf("m1[%0d] in_ready", i), 32'(m1_in_ready), 32'(m1_tab[i].eir));
        end

        // Counter saturation, clear, then reset mid-stream.
        in_valid = '0; kill_mask = '0; flush = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; stall_up = 1'b1; stall_down = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) step();
        chk("sat m0 stall_cnt", 32'(m0_stall_cnt), 32'hF);
        chk("sat m0 bubble_cnt", 32'(m0_bubble_cnt), 32'h0);
        chk("sat m1 bubble_cnt", 32'(m1_bubble_cnt), 32'hF);
        chk("sat m1 stall_cnt", 32'(m1_stall_cnt), 32'h0);
        cnt_clr = 1'b1;
        step();
        chk("clr m0 stall_cnt", 32'(m0_stall_cnt), 32'h0);
        chk("clr m1 bubble_cnt", 32'(m1_bubble_cnt), 32'h0);
        cnt_clr = 1'b0; stall_up = 1'b0; stall_down = 1'b0;
        in_valid = 2'b11; in_data = 16'hC3C3;
        step();
        chk("midstream m0 out_valid", 32'(m0_out_valid), 32'h3);
        chk("midstream m1 out_valid", 32'(m1_out_valid), 32'h3);
        in_data = 16'h3C3C;
        step();
        rst = 1'b1;
        step();
        chk_reset_state("mid reset");
        rst = 1'b0; in_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
